// File: rtl/mux_scan_n_if.sv
// mux_scan_n bus: channel data, select/mode controls and registered outputs.
// ch_mask exists only when MUX_SCAN_SKIP_EN is defined.
interface mux_scan_n_if #(
  parameter int CHANNELS = 7,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = 3
);
  logic [CHANNELS*WIDTH-1:0] in;
  logic [SEL_W-1:0]          sel;
  logic                      mode;
  logic                      enable;
`ifdef MUX_SCAN_SKIP_EN
  logic [CHANNELS-1:0]       ch_mask;
`endif
  logic [WIDTH-1:0]          out;
  logic                      out_valid;
  logic [SEL_W-1:0]          cur_ch;
  logic                      wrap;

`ifdef MUX_SCAN_SKIP_EN
  modport master (
    output in, sel, mode, enable, ch_mask,
    input  out, out_valid, cur_ch, wrap
  );
  modport slave (
    input  in, sel, mode, enable, ch_mask,
    output out, out_valid, cur_ch, wrap
  );
`else
  modport master (
    output in, sel, mode, enable,
    input  out, out_valid, cur_ch, wrap
  );
  modport slave (
    input  in, sel, mode, enable,
    output out, out_valid, cur_ch, wrap
  );
`endif
endinterface

// File: rtl/mux_scan_n.sv
// N-channel registered selector with manual select and dwell-timed scan.
// Optional MUX_SCAN_SKIP_EN adds ch_mask to skip channels while scanning.
module mux_scan_n #(
  parameter int CHANNELS = 7,
  parameter int WIDTH    = 1,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input logic         clk,
  input logic         reset,
  mux_scan_n_if.slave bus
);
  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {S_MANUAL, S_SCAN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic [SEL_W-1:0] r_ch;
  logic             r_wrap;

  logic             w_any;
  logic [SEL_W-1:0] w_first;
  logic [SEL_W-1:0] w_adv_ch;
  logic             w_adv_wrap;
  logic             w_do_adv;
  logic [SEL_W-1:0] w_scan_ch;
  logic [WIDTH-1:0] w_scan_data;
  logic [WIDTH-1:0] w_man_data;
  logic             w_man_ok;

`ifdef MUX_SCAN_SKIP_EN
  logic             w_hi_found;
  logic [SEL_W-1:0] w_hi_ch;

  // Lowest unmasked channel, and lowest unmasked channel above r_ch.
  always_comb begin
    w_any      = |bus.ch_mask;
    w_first    = '0;
    w_hi_found = 1'b0;
    w_hi_ch    = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (bus.ch_mask[k]) begin
        w_first = SEL_W'(k);
        if (SEL_W'(k) > r_ch) begin
          w_hi_found = 1'b1;
          w_hi_ch    = SEL_W'(k);
        end
      end
    end
    w_adv_ch   = w_hi_found ? w_hi_ch : w_first;
    w_adv_wrap = !w_hi_found;
  end
`else
  localparam logic [SEL_W-1:0] LP_TOP = SEL_W'(CHANNELS - 1);

  // Plain modulo-CHANNELS step through every channel.
  always_comb begin
    w_any      = 1'b1;
    w_first    = '0;
    w_adv_wrap = (r_ch == LP_TOP);
    w_adv_ch   = w_adv_wrap ? '0 : r_ch + 1'b1;
  end
`endif

  // Channel cur_ch will hold after this edge in scan, plus data lookups.
  always_comb begin
    w_do_adv    = bus.enable && (r_cnt == LP_LAST);
    w_scan_ch   = (r_state == S_MANUAL) ? w_first :
                  (w_do_adv ? w_adv_ch : r_ch);
    w_scan_data = '0;
    w_man_data  = '0;
    w_man_ok    = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (bus.sel == SEL_W'(k)) begin
        w_man_ok   = 1'b1;
        w_man_data = bus.in[k*WIDTH +: WIDTH];
      end
      if (w_scan_ch == SEL_W'(k))
        w_scan_data = bus.in[k*WIDTH +: WIDTH];
    end
  end

  // Mode FSM with registered out/out_valid/cur_ch/wrap and dwell counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_MANUAL;
      r_cnt   <= '0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_wrap  <= 1'b0;
    end else if (!bus.mode) begin
      r_state <= S_MANUAL;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
      r_ch    <= bus.sel;
      r_valid <= w_man_ok;
      r_out   <= w_man_data;
    end else if (r_state == S_MANUAL) begin
      r_state <= S_SCAN;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
      r_ch    <= w_first;
      r_valid <= w_any;
      r_out   <= w_any ? w_scan_data : '0;
    end else if (!w_any) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (bus.enable) begin
      r_valid <= 1'b1;
      r_out   <= w_scan_data;
      r_ch    <= w_scan_ch;
      if (r_cnt == LP_LAST) begin
        r_cnt  <= '0;
        r_wrap <= w_adv_wrap;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
        r_wrap <= 1'b0;
      end
    end else begin
      r_valid <= 1'b1;
      r_out   <= w_scan_data;
      r_wrap  <= 1'b0;
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_valid;
  assign bus.cur_ch    = r_ch;
  assign bus.wrap      = r_wrap;

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n (7 x 1-bit, dwell 4).
// Builds with or without MUX_SCAN_SKIP_EN.
module tb_mux_scan_n;
  localparam int CH    = 7;
  localparam int W     = 1;
  localparam int SW    = 3;
  localparam int DWELL = 4;

  typedef struct {
    logic [W-1:0]  out;
    logic          v;
    logic [SW-1:0] ch;
    logic          w;
  } exp_t;

  logic          clk = 1'b0;
  logic          tb_rst = 1'b1;
  logic [CH-1:0] tb_in = '0;
  logic [SW-1:0] tb_sel = '0;
  logic          tb_mode = 1'b0;
  logic          tb_en = 1'b0;
  logic [CH-1:0] tb_mask = '1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_scan  = 0;
  int m_cnt   = 0;
  int m_ch    = 0;
  exp_t sb[$];

  mux_scan_n_if #(.CHANNELS(CH), .WIDTH(W), .SEL_W(SW)) dut_if ();

  assign dut_if.in     = tb_in;
  assign dut_if.sel    = tb_sel;
  assign dut_if.mode   = tb_mode;
  assign dut_if.enable = tb_en;
`ifdef MUX_SCAN_SKIP_EN
  assign dut_if.ch_mask = tb_mask;
`endif

  mux_scan_n #(
    .CHANNELS(CH), .WIDTH(W), .SEL_W(SW), .DWELL(DWELL)
  ) u_dut (
    .clk   (clk),
    .reset (tb_rst),
    .bus   (dut_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic logic mbit(input int n);
    return 1'(tb_mask >> n);
  endfunction

  function automatic logic [W-1:0] chan(input int n);
    return W'(tb_in >> (n * W));
  endfunction

  task automatic model_push();
    exp_t e;
    int   n;
    e = '{out: '0, v: 1'b0, ch: '0, w: 1'b0};
    if (tb_rst) begin
      m_scan = 0; m_cnt = 0; m_ch = 0;
    end else if (!tb_mode) begin
      m_scan = 0; m_cnt = 0; m_ch = int'(tb_sel);
      e.ch = tb_sel;
      if (m_ch < CH) begin
        e.v = 1'b1; e.out = chan(m_ch);
      end
    end else if (m_scan == 0) begin
      m_scan = 1; m_cnt = 0; m_ch = 0;
      for (int k = CH - 1; k >= 0; k--)
        if (mbit(k)) m_ch = k;
      e.ch = SW'(m_ch);
      if (tb_mask != '0) begin
        e.v = 1'b1; e.out = chan(m_ch);
      end
    end else if (tb_mask == '0) begin
      e.ch = SW'(m_ch);
    end else begin
      if (tb_en) begin
        if (m_cnt == DWELL - 1) begin
          m_cnt = 0;
          n = m_ch;
          do begin
            n = (n + 1) % CH;
            if (n == 0) e.w = 1'b1;
          end while (!mbit(n));
          m_ch = n;
        end else begin
          m_cnt++;
        end
      end
      e.ch = SW'(m_ch); e.v = 1'b1; e.out = chan(m_ch);
    end
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("out",    32'(dut_if.out),       32'(e.out));
      chk("valid",  32'(dut_if.out_valid), 32'(e.v));
      chk("cur_ch", 32'(dut_if.cur_ch),    32'(e.ch));
      chk("wrap",   32'(dut_if.wrap),      32'(e.w));
    end
  endtask

  int last_wrap;
  int n_wrap;

  initial begin
    // reset held with scan requested
    tb_rst = 1'b1; tb_in = 7'b1010101; tb_mode = 1'b1; tb_en = 1'b1;
    step(); step();
    chk("rst_valid", 32'(dut_if.out_valid), 0);
    chk("rst_ch",    32'(dut_if.cur_ch),    0);
    tb_rst = 1'b0;
    step();
    chk("entry_ch",    32'(dut_if.cur_ch),    0);
    chk("entry_valid", 32'(dut_if.out_valid), 1);

    // manual select
    tb_mode = 1'b0; tb_in = 7'b0100000; tb_sel = 3'd5;
    step();
    chk("man5_out",   32'(dut_if.out),       1);
    chk("man5_valid", 32'(dut_if.out_valid), 1);
    tb_sel = 3'd7;
    step();
    chk("man7_out",   32'(dut_if.out),       0);
    chk("man7_valid", 32'(dut_if.out_valid), 0);
    for (int s = 0; s < 8; s++) begin
      tb_sel = SW'(s); tb_in = CH'($urandom);
      step();
    end

    // full scan period, every channel high
    tb_in = '1; tb_mode = 1'b1; tb_en = 1'b1;
    step();
    last_wrap = -1; n_wrap = 0;
    for (int t = 1; t <= 60; t++) begin
      if (t > 30) tb_in = CH'($urandom);
      step();
      if (dut_if.wrap) begin
        n_wrap++;
        if (last_wrap >= 0) chk("wrap_period", t - last_wrap, 28);
        last_wrap = t;
      end
    end
    chk("wrap_count", n_wrap, 2);

    // freeze at ch 3, counter 2
    tb_mode = 1'b0; step();
    tb_mode = 1'b1; step();
    for (int t = 0; t < 14; t++) step();
    chk("pre_freeze_ch", 32'(dut_if.cur_ch), 3);
    tb_en = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tb_in = tb_in ^ 7'b0001000;
      step();
    end
    chk("freeze_ch", 32'(dut_if.cur_ch), 3);
    chk("freeze_out", 32'(dut_if.out), 32'(tb_in[3]));
    tb_en = 1'b1;
    step();
    chk("resume1_ch", 32'(dut_if.cur_ch), 3);
    step();
    chk("resume2_ch", 32'(dut_if.cur_ch), 4);

    // leave scan, then reset mid-scan
    tb_mode = 1'b0; tb_sel = 3'd1;
    step();
    chk("leave_ch",   32'(dut_if.cur_ch), 1);
    chk("leave_wrap", 32'(dut_if.wrap),   0);
    tb_mode = 1'b1; tb_in = '1;
    for (int t = 0; t < 6; t++) step();
    tb_rst = 1'b1;
    step();
    chk("midrst_out", 32'(dut_if.out),       0);
    chk("midrst_v",   32'(dut_if.out_valid), 0);
    tb_rst = 1'b0;

`ifdef MUX_SCAN_SKIP_EN
    tb_mask = 7'b1000101; tb_mode = 1'b0; step();
    tb_mode = 1'b1; step();
    n_wrap = 0;
    for (int t = 0; t < 24; t++) begin
      step();
      if (dut_if.wrap) n_wrap++;
    end
    chk("skip_wraps", n_wrap, 2);
    tb_mask = '0;
    for (int t = 0; t < 5; t++) step();
    chk("skip_empty_v", 32'(dut_if.out_valid), 0);
    tb_mask = '1;
`endif

    // random traffic
    for (int t = 0; t < 400; t++) begin
      tb_rst  = ($urandom_range(0, 40) == 0);
      tb_mode = ($urandom_range(0, 9) != 0);
      tb_en   = ($urandom_range(0, 3) != 0);
      tb_sel  = SW'($urandom);
      tb_in   = CH'($urandom);
`ifdef MUX_SCAN_SKIP_EN
      if ($urandom_range(0, 15) == 0) tb_mask = CH'($urandom);
`endif
      step();
    end
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised N-channel, W-bit registered selector; next generation of the 7-to-1 switch-board mux.
- Manual mode: selects the channel given by sel.
- Scan mode: an internal sequencer steps through all channels, holding each for a programmable dwell time.
- Drives board-level outputs (LEDR / HEX decoders) from one clock domain.

Parameters:
- CHANNELS, 7, number of input channels (2..16).
- WIDTH, 1, bits per channel.
- SEL_W, 3, width of sel and cur_ch; must be >= clog2(CHANNELS).
- DWELL, 4, cycles each channel is held in scan mode (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  CHANNELS*WIDTH  packed channels; channel k = in[k*WIDTH +: WIDTH].
- sel  input  SEL_W  manual channel select.
- mode  input  1  0 = manual, 1 = scan.
- enable  input  1  scan advance enable; ignored in manual mode.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  out holds a legal channel.
- cur_ch  output  SEL_W  channel currently driving out.
- wrap  output  1  one-cycle pulse when scan steps from channel CHANNELS-1 to 0.

Behaviour:
- Interface fixed: single clock clk; reset is synchronous and active-high.
- Reset (sampled high on a clk edge): out=0, out_valid=0, cur_ch=0, wrap=0, dwell counter=0, state=MANUAL. Reset overrides all other inputs, including mid-scan.
- States: MANUAL, SCAN.
  - MANUAL -> SCAN when mode=1 is sampled.
  - SCAN -> MANUAL when mode=0 is sampled.
- Latency: out, out_valid and cur_ch are registered, with 1-cycle latency from in/sel/mode.
- MANUAL, sel < CHANNELS: next out = channel sel, out_valid=1, cur_ch=sel.
- MANUAL, sel >= CHANNELS: out=0, out_valid=0, cur_ch=sel.
- Entering SCAN: the first SCAN cycle forces cur_ch=0, counter=0 and out=channel 0, regardless of the previous sel.
- SCAN, enable=1:
  - counter increments each cycle.
  - When counter == DWELL-1, counter clears and cur_ch advances by 1.
  - From cur_ch=CHANNELS-1 it wraps to 0, and wrap=1 for exactly that cycle.
- SCAN, enable=0: counter and cur_ch freeze. out keeps tracking live data of cur_ch every cycle. wrap=0.
- DWELL=1: channel advances on every enabled cycle.
- out in SCAN always reflects in[cur_ch] as sampled on the same edge that registers cur_ch, so out and cur_ch stay coherent. out_valid=1 throughout SCAN.
- Leaving SCAN: the next cycle behaves as MANUAL with the current sel. Counter clears and wrap=0.
- wrap is never asserted in MANUAL.
- Data is passed unmodified; no arithmetic on data.
- Counter width is clog2(DWELL)+1 and must not overflow.

Optional Feature:
- Macro: MUX_SCAN_SKIP_EN.
- Defined:
  - Adds input port ch_mask [CHANNELS-1:0].
  - Scan advance moves to the next higher channel whose mask bit is 1, wrapping modulo CHANNELS. wrap pulses whenever the advance passes through index CHANNELS-1 -> 0.
  - Scan entry starts at the lowest unmasked channel.
  - If ch_mask == 0 in SCAN: out=0, out_valid=0, cur_ch holds, counter holds.
  - Manual mode ignores ch_mask.
- Undefined: no ch_mask port; every channel is scanned.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in=7'b1010101, mode=1 -> out=0, out_valid=0, cur_ch=0, wrap=0. First cycle after release: state SCAN, cur_ch=0.
- Manual select (CHANNELS=7, WIDTH=1): in=7'b0100000, sel=5 -> one cycle later out=1, out_valid=1, cur_ch=5. sel=7 -> out=0, out_valid=0.
- Scan sequence (DWELL=4, enable=1, in=7'b1111111): cur_ch steps 0,1,...,6,0 every 4 cycles. wrap=1 in exactly the cycle cur_ch goes 6 -> 0; a full period is 28 cycles.
- Freeze: in SCAN at cur_ch=3, counter=2, drop enable for 10 cycles -> cur_ch stays 3. Toggling in[3] shows on out with 1-cycle latency. Restore enable -> advances to 4 after 2 more cycles.
- Mode switch / mid-op reset: in SCAN at cur_ch=4, set mode=0 with sel=1 -> next cycle cur_ch=1, wrap=0. Assert reset during SCAN -> all outputs 0 on the next edge.
- Skip (MUX_SCAN_SKIP_EN, ch_mask=7'b1000101): scan order is 0,2,6,0 with wrap on 6 -> 0. ch_mask=0 -> out_valid=0 and cur_ch holds.
